rv32_divider: RTL and testbench
===============================

# rv32_divider

Iterative radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU operations. It sits in the execute stage of the RV32I pipeline beside the combinational ALU. It accepts operands on a start pulse and holds the pipeline through busy_o until the result is ready. Results, including divide-by-zero and signed-overflow cases, follow RISC-V semantics exactly.

## Interface
- WIDTH, 32, operand and result width; iteration count equals WIDTH
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request a division; sampled only in IDLE or DONE
- op_i  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU
- val1_i  input  WIDTH  dividend; sampled with start_i
- val2_i  input  WIDTH  divisor; sampled with start_i
- flush_i  input  1  abort the in-flight operation (pipeline flush)
- busy_o  output  1  high in CALC and FIX; the pipeline stalls the execute stage while high
- done_o  output  1  one-cycle pulse; result_o is valid this cycle
- result_o  output  WIDTH  quotient or remainder; holds until the next done_o or reset

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1:
  - Latch op_i.
  - If the divisor is 0, or the operation is signed with dividend 0x8000_0000 and divisor 0xFFFF_FFFF, compute the special result and go to DONE.
  - Otherwise go to CALC.
  - In the same edge, load the magnitudes: absolute values for DIV/REM, raw values for DIVU/REMU.
  - Record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1), both for signed ops only.
  - Clear the iteration counter.
- Special results:
  - Divide by zero: quotient = all ones (DIV and DIVU), remainder = dividend (REM and REMU).
  - Signed overflow: DIV = 0x8000_0000, REM = 0.
- CALC: one quotient bit per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem using a WIDTH+1-bit subtract.
  - If the result is non-negative, commit it and set quo[0]=1.
  - After WIDTH iterations (counter = WIDTH-1), go to FIX.
- FIX:
  - Select quotient or remainder per op.
  - For signed ops, negate the quotient if its sign flag is set, and negate the remainder if its sign flag is set.
  - Register the value into result_o and go to DONE.
- DONE:
  - done_o=1 for exactly this cycle.
  - Next state is IDLE, or back-to-back acceptance if start_i=1.
- IDLE/DONE with start_i=0: go to or stay in IDLE.
- start_i in CALC or FIX is ignored; no queuing.
- Control priority: rst_i > flush_i > start_i.
- flush_i in any state:
  - Next state is IDLE; done_o is not asserted for the aborted operation.
  - result_o keeps its previous value.
  - flush_i together with start_i in IDLE: the start is dropped.
- The signed remainder takes the sign of the dividend. The magnitude path uses unsigned arithmetic throughout; the 0x8000_0000 magnitude is representable in WIDTH unsigned bits.

## Timing
- Reset values: state IDLE, busy_o=0, done_o=0, result_o=0, and all internal registers 0.
- Normal operation, with start_i in cycle 0:
  - CALC occupies cycles 1..WIDTH (1..32).
  - FIX is in cycle WIDTH+1 (33).
  - done_o=1 in cycle WIDTH+2 (34).
  - Latency is WIDTH+2 cycles.
- Special case: done_o=1 in cycle 1, busy_o stays 0, and latency is 1 cycle.
- busy_o is registered from state; it is high from cycle 1 through cycle WIDTH+1.
- Back-to-back: start_i in the DONE cycle is accepted. The next operation's CALC begins the following cycle, giving a throughput of one result per WIDTH+2 cycles.
- Reset mid-operation: the next cycle is IDLE with reset values on all outputs.

## Test plan
- DIVU 100/7, start in cycle 0 -> busy_o high cycles 1-33; done_o in cycle 34 only; result_o=14. Repeat with REMU -> 2.
- DIV 0xFFFF_FF9C (-100) / 7 -> 0xFFFF_FFF2 (-14). REM -100/7 -> 0xFFFF_FFFE (-2). REM 100/-7 -> 2.
- Divide by zero, 1234/0 -> DIV and DIVU give 0xFFFF_FFFF; REM and REMU give 1234 (0x4D2). done_o in cycle 1; busy_o never high.
- Overflow, 0x8000_0000 / 0xFFFF_FFFF -> DIV gives 0x8000_0000 and REM gives 0, both with 1-cycle latency. DIVU on the same operands gives 0 after 34 cycles.
- flush_i asserted in cycle 10 of a DIVU -> IDLE in cycle 11; no done_o; result_o unchanged. start_i asserted in cycle 5 of an operation -> ignored.
- Back-to-back: start 0xFFFF_FFFF/1 (DIVU), then start 7/2 (DIVU) in its DONE cycle -> results 0xFFFF_FFFF then 3, with done_o pulses 34 cycles apart. rst_i mid-CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rv32_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, then a sign-fix cycle; special cases finish in one cycle.
module rv32_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] val1_i,
  input  logic [WIDTH-1:0] val2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q, rneg_q, busy_q, done_q;

  logic             signed_op, neg1, neg2, div_zero, ovf;
  logic [WIDTH-1:0] mag1, mag2, special_res, quo_fix, rem_fix, fix_res;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    signed_op   = ~op_i[0];
    neg1        = signed_op & val1_i[WIDTH-1];
    neg2        = signed_op & val2_i[WIDTH-1];
    mag1        = neg1 ? (~val1_i + 1'b1) : val1_i;
    mag2        = neg2 ? (~val2_i + 1'b1) : val2_i;
    div_zero    = (val2_i == '0);
    ovf         = signed_op && (val1_i == MIN_NEG) && (&val2_i);
    special_res = div_zero ? (op_i[1] ? val1_i : '1)
                           : (op_i[1] ? '0 : MIN_NEG);
    // WIDTH+1-bit trial subtract: bit WIDTH set means the shifted remainder was below the divisor
    shifted     = {rem_q, quo_q[WIDTH-1]};
    trial       = shifted - {1'b0, div_q};
    quo_fix     = qneg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix     = rneg_q ? (~rem_q + 1'b1) : rem_q;
    fix_res     = op_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start_i) begin
              op_q   <= op_i;
              cnt_q  <= '0;
              rem_q  <= '0;
              quo_q  <= mag1;
              div_q  <= mag2;
              qneg_q <= neg1 ^ neg2;
              rneg_q <= neg1;
              if (div_zero || ovf) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
                result_q <= special_res;
              end else begin
                state_q <= CALC;
                busy_q  <= 1'b1;
              end
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          CALC: begin
            if (!trial[WIDTH]) begin
              rem_q <= trial[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= shifted[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_q <= FIX;
          end
          FIX: begin
            result_q <= fix_res;
            state_q  <= DONE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_rv32_divider.sv
// Scoreboard bench for rv32_divider: directed vectors push expected result and done cycle,
// a negedge monitor pops and compares on every done_o pulse.
module tb_rv32_divider;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] val1_i, val2_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  rv32_divider #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .val1_i(val1_i), .val2_i(val2_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [31:0] res; int at; } exp_t;
  exp_t sb_q[$];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (sb_q.size() == 0) chk("spurious_done", {31'b0, done_o}, 32'd0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result_o, e.res);
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  // Called at a negedge: drives the start for this cycle (cycle 0)
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    start_i = 1'b1; op_i = op; val1_i = a; val2_i = b;
    sb_q.push_back('{exp, cyc + lat});
  endtask

  // Steps through cycles 1..lat, counting busy; ends at the negedge of the done cycle
  task automatic wait_done(input int lat);
    int nb = 0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (busy_o) nb++;
    end
    chk("busy_cycles", nb, (lat == 34) ? 32'd33 : 32'd0);
    chk("done_at_latency", {31'b0, done_o}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    @(negedge clk_i);
    issue(op, a, b, exp, lat);
    wait_done(lat);
  endtask

  typedef struct { logic [1:0] op; logic [31:0] a, b, exp; int lat; } vec_t;
  vec_t vecs[$];

  initial begin
    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         34});
    vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          34});
    vecs.push_back('{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  34});
    vecs.push_back('{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  34});
    vecs.push_back('{2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          34});
    vecs.push_back('{2'b00, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  34});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  34});
    vecs.push_back('{2'b00, 32'd1234,       32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b01, 32'd1234,       32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b10, 32'd1234,       32'd0,          32'h0000_04D2,  1});
    vecs.push_back('{2'b11, 32'd1234,       32'd0,          32'h0000_04D2,  1});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34});
    vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; val1_i = '0; val2_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_done", {31'b0, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    rst_i = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush in cycle 10 of a DIVU; a special-case start in cycle 5 must be ignored
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; val1_i = 32'd50; val2_i = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i);
      start_i = (i == 5);
      if (i == 5) begin op_i = 2'b01; val1_i = 32'd1234; val2_i = 32'd0; end
      if (i == 10) begin
        chk("busy_before_flush", {31'b0, busy_o}, 32'd1);
        flush_i = 1'b1;
      end
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_result_kept", result_o, 32'h8000_0000);
    repeat (30) @(negedge clk_i);
    chk("flush_idle_busy", {31'b0, busy_o}, 32'd0);

    // Start together with flush in IDLE is dropped
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; val1_i = 32'd9; val2_i = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", {31'b0, busy_o}, 32'd0);
    repeat (3) @(negedge clk_i);

    // Back-to-back: second start issued in the first op's DONE cycle
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    issue(2'b01, 32'd7, 32'd2, 32'd3, 34);
    wait_done(34);

    // Reset mid-CALC clears all outputs on the next cycle
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; val1_i = 32'd100; val2_i = 32'd7;
    repeat (5) begin @(negedge clk_i); start_i = 1'b0; end
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_mid_done", {31'b0, done_o}, 32'd0);
    chk("rst_mid_result", result_o, 32'd0);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
